// File: rtl/sar_adc_pkg.sv
// Shared types and default sizing for the SAR ADC conversion engine.
// Optional comparator synchronizer is selected with SAR_ADC_COMP_SYNC_EN.
package sar_adc_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SAMPLE  = 2'd1,
        CONVERT = 2'd2,
        DONE    = 2'd3
    } sar_state_t;

    localparam int DEF_ADC_WIDTH    = 8;
    localparam int DEF_NUM_CH       = 6;
    localparam int DEF_SAMPLE_TICKS = 2;
    localparam int DEF_SETTLE_TICKS = 1;

endpackage

// File: rtl/sar_adc_sync.sv
// Two-flop synchronizer bringing the asynchronous comparator output into the mclk domain.
// Only instantiated when SAR_ADC_COMP_SYNC_EN is defined.
module sar_adc_sync (
    input  logic clk,
    input  logic srst,
    input  logic d,
    output logic q
);

    logic [1:0] sync_reg;

    always_ff @(posedge clk) begin
        if (srst) begin
            sync_reg <= '0;
        end else begin
            sync_reg <= {sync_reg[0], d};
        end
    end

    assign q = sync_reg[1];

endmodule

// File: rtl/sar_adc_ctrl.sv
// SAR conversion engine: sample/hold sequencing, binary search of the DAC code against the
// comparator, result hand-back. Define SAR_ADC_COMP_SYNC_EN to synchronize comp_in.
module sar_adc_ctrl
    import sar_adc_pkg::*;
#(
    parameter int ADC_WIDTH    = DEF_ADC_WIDTH,
    parameter int NUM_CH       = DEF_NUM_CH,
    parameter int SAMPLE_TICKS = DEF_SAMPLE_TICKS,
    parameter int SETTLE_TICKS = DEF_SETTLE_TICKS
) (
    input  logic                 mclk,
    input  logic                 reset,
    input  logic                 pulse1m_mclk,
    input  logic                 start_conv,
    input  logic [2:0]           adc_ch_no,
    input  logic                 comp_in,
    output logic                 conv_done,
    output logic [ADC_WIDTH-1:0] adc_result,
    output logic [ADC_WIDTH-1:0] dac_code,
    output logic                 sample_en,
    output logic [NUM_CH-1:0]    ch_sel
);

    localparam int MAX_TICKS = (SAMPLE_TICKS > SETTLE_TICKS) ? SAMPLE_TICKS : SETTLE_TICKS;
    localparam int CNT_W     = (MAX_TICKS > 1) ? $clog2(MAX_TICKS) : 1;
    localparam int BIT_W     = (ADC_WIDTH > 1) ? $clog2(ADC_WIDTH) : 1;

    sar_state_t           state_reg;
    logic [CNT_W-1:0]     cnt_reg;
    logic [BIT_W-1:0]     bit_reg;
    logic                 comp_bit;
    logic [NUM_CH-1:0]    ch_onehot;
    logic [ADC_WIDTH-1:0] next_trial_mask;
    logic [ADC_WIDTH-1:0] resolved_code;

`ifdef SAR_ADC_COMP_SYNC_EN
    sar_adc_sync u_comp_sync (
        .clk  (mclk),
        .srst (reset),
        .d    (comp_in),
        .q    (comp_bit)
    );
`else
    assign comp_bit = comp_in;
`endif

    // Out-of-range channel numbers decode to no mux select; the conversion still runs.
    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch_dec
            assign ch_onehot[gi] = (32'(adc_ch_no) == gi);
        end
        for (genvar gi = 0; gi < ADC_WIDTH; gi++) begin : g_trial_mask
            assign next_trial_mask[gi] = (32'(bit_reg) == gi + 1);
        end
    endgenerate

    always_comb begin
        resolved_code = dac_code;
        if (!comp_bit) begin
            resolved_code[bit_reg] = 1'b0;
        end
    end

    always_ff @(posedge mclk) begin
        if (reset) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            bit_reg    <= '0;
            conv_done  <= 1'b0;
            adc_result <= '0;
            dac_code   <= '0;
            sample_en  <= 1'b0;
            ch_sel     <= '0;
        end else if (pulse1m_mclk) begin
            case (state_reg)
                IDLE: begin
                    if (start_conv) begin
                        ch_sel    <= ch_onehot;
                        sample_en <= 1'b1;
                        cnt_reg   <= CNT_W'(SAMPLE_TICKS - 1);
                        state_reg <= SAMPLE;
                    end
                end
                SAMPLE: begin
                    if (!start_conv) begin
                        sample_en <= 1'b0;
                        ch_sel    <= '0;
                        dac_code  <= '0;
                        state_reg <= IDLE;
                    end else if (cnt_reg == '0) begin
                        sample_en <= 1'b0;
                        dac_code  <= ADC_WIDTH'(1) << (ADC_WIDTH - 1);
                        bit_reg   <= BIT_W'(ADC_WIDTH - 1);
                        cnt_reg   <= CNT_W'(SETTLE_TICKS - 1);
                        state_reg <= CONVERT;
                    end else begin
                        cnt_reg <= cnt_reg - CNT_W'(1);
                    end
                end
                CONVERT: begin
                    if (!start_conv) begin
                        ch_sel    <= '0;
                        dac_code  <= '0;
                        state_reg <= IDLE;
                    end else if (cnt_reg == '0) begin
                        if (bit_reg == '0) begin
                            dac_code   <= resolved_code;
                            adc_result <= resolved_code;
                            conv_done  <= 1'b1;
                            state_reg  <= DONE;
                        end else begin
                            dac_code <= resolved_code | next_trial_mask;
                            bit_reg  <= bit_reg - BIT_W'(1);
                            cnt_reg  <= CNT_W'(SETTLE_TICKS - 1);
                        end
                    end else begin
                        cnt_reg <= cnt_reg - CNT_W'(1);
                    end
                end
                DONE: begin
                    // Requester must drop start_conv before another conversion can begin.
                    if (!start_conv) begin
                        conv_done <= 1'b0;
                        ch_sel    <= '0;
                        dac_code  <= '0;
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule
